nios2core_onchip_memory_dp: RTL and testbench
=============================================

NIOS2CORE_ONCHIP_MEMORY_DP -- requirements
Module: nios2core_onchip_memory_dp

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8, range 8..128.
REQ-002 Parameter ADDR_WIDTH, default 12, word address width; depth SHALL be 2**ADDR_WIDTH words.
REQ-003 Parameter READ_LATENCY, default 1, read latency in cycles; legal values 1 or 2 only.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset_n  in  1  reset; synchronous, active-low.
REQ-006 clken  in  1  global clock enable; low freezes all state.
REQ-007 reset_req  in  1  reset-pending request; high behaves exactly as clken low.
REQ-008 s1_address  in  ADDR_WIDTH  port 1 word address.
REQ-009 s1_chipselect, s1_read, s1_write  in  1 each  port 1 command qualifiers.
REQ-010 s1_byteenable  in  DATA_WIDTH/8  port 1 byte-lane write enables.
REQ-011 s1_writedata  in  DATA_WIDTH  port 1 write data.
REQ-012 s1_readdata  out  DATA_WIDTH  port 1 read data.
REQ-013 s1_readdatavalid  out  1  port 1 read data qualifier.
REQ-014 s2_* ports SHALL mirror REQ-008..REQ-013 for port 2.
REQ-015 collision_count  out  16  saturating count of same-address write collisions.

Function
REQ-016 Enable term en = clken & ~reset_req; when en is low no memory write, pipeline advance or counter update SHALL occur, and all outputs SHALL hold.
REQ-017 Port n write accepted on an edge where en & sn_chipselect & sn_write; byte lane k SHALL be written only if sn_byteenable[k] is set.
REQ-018 Port n read accepted on an edge where en & sn_chipselect & sn_read & ~sn_write; read and write asserted together SHALL be a write only, with no readdatavalid.
REQ-019 No waitrequest; every command SHALL be accepted in the cycle presented (when en is high), allowing back-to-back reads every cycle on both ports.
REQ-020 Read accepted at edge N: sn_readdata valid and sn_readdatavalid high for exactly one cycle after edge N+READ_LATENCY-1 (latency 1: after edge N; latency 2: after edge N+1).
REQ-021 READ_LATENCY=2 SHALL add one output register stage; valid pipeline SHALL shift in lockstep with data, including freeze under REQ-016.
REQ-022 sn_readdata SHALL hold its last value when sn_readdatavalid is low.
REQ-023 Cross-port read of a word written in the same accepted cycle SHALL return the old (pre-write) data; read in the following cycle SHALL return the new data.
REQ-024 Both ports writing the same address in the same cycle: lanes enabled by s1 SHALL take s1 data; lanes enabled only by s2 SHALL take s2 data.
REQ-025 collision_count SHALL increment by 1 on each such same-address write cycle where (s1_byteenable & s2_byteenable) != 0, and SHALL saturate at 16'hFFFF.
REQ-026 Address range is exactly the full ADDR_WIDTH space; no out-of-range condition exists, and address 2**ADDR_WIDTH-1 SHALL be fully usable.
REQ-027 The array SHALL be inferable as true dual-port block RAM with byte enables; no vendor megafunction instantiation.

Reset
REQ-028 With reset_n low at a clock edge: s1/s2_readdatavalid, all in-flight valid bits and collision_count SHALL go to 0; s1/s2_readdata SHALL go to 0.
REQ-029 Reset SHALL take effect regardless of clken and reset_req.
REQ-030 Reset SHALL NOT clear memory contents; reads in flight at reset SHALL be discarded (no readdatavalid after reset release).
REQ-031 Post-reset memory contents are undefined until written.

Verification
REQ-032 READ_LATENCY=1: s1 writes 0xDEADBEEF to addr 0x005, s2 reads 0x005 next cycle -> s2_readdatavalid high one cycle later, s2_readdata=0xDEADBEEF.
REQ-033 Byte enables: write 0x11223344 with be=4'b1111, then 0xAABBCCDD with be=4'b0101 to addr 0xFFF -> read returns 0x11BB33DD.
REQ-034 Collision: both ports write addr 0x010, s1 0x000000AA be=0001, s2 0x0000BB00 be=0011 -> word reads 0x0000BBAA, collision_count 0->1; repeat with be 0001/0010 -> count unchanged.
REQ-035 READ_LATENCY=2: s1 reads addrs 0,1,2 back-to-back, clken low for 2 cycles mid-stream -> three valid pulses, correct order, data held during freeze, no extra pulse.
REQ-036 Reset mid-read: s1 read accepted, reset_n low on next edge -> no s1_readdatavalid pulse, collision_count=0, previously written data still readable after release.

Source files
------------

// File: rtl/nios2core_onchip_memory_dp_if.sv
// One Avalon-style memory slave port: command qualifiers, byte-enabled write data
// and a read return channel qualified by readdatavalid.
interface nios2core_onchip_memory_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/nios2core_onchip_memory_dp.sv
// True dual-port on-chip RAM with byte enables, 1- or 2-cycle read latency and a
// saturating counter of same-address, overlapping-lane write collisions.
module nios2core_onchip_memory_dp #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clken,
  input  logic                          reset_req,
  nios2core_onchip_memory_dp_if.slave   s1,
  nios2core_onchip_memory_dp_if.slave   s2,
  output logic [15:0]                   collision_count
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  en;
  logic [ADDR_WIDTH-1:0] addr  [2];
  logic [NB-1:0]         be    [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic                  wr    [2];
  logic                  rd    [2];
  logic                  collide;

  assign en = clken & ~reset_req;

  assign addr[0]  = s1.address;
  assign addr[1]  = s2.address;
  assign be[0]    = s1.byteenable;
  assign be[1]    = s2.byteenable;
  assign wdata[0] = s1.writedata;
  assign wdata[1] = s2.writedata;
  assign wr[0]    = s1.chipselect & s1.write;
  assign wr[1]    = s2.chipselect & s2.write;
  assign rd[0]    = s1.chipselect & s1.read & ~s1.write;
  assign rd[1]    = s2.chipselect & s2.read & ~s2.write;

  assign collide = wr[0] & wr[1] & (addr[0] == addr[1]) & (|(be[0] & be[1]));

  // Port 1 lanes are assigned last so they win over port 2 on a shared address.
  always_ff @(posedge clk) begin : mem_write
    if (en) begin
      for (int k = 0; k < NB; k++) begin
        if (wr[1] && be[1][k]) mem[addr[1]][k*8 +: 8] <= wdata[1][k*8 +: 8];
        if (wr[0] && be[0][k]) mem[addr[0]][k*8 +: 8] <= wdata[0][k*8 +: 8];
      end
    end
  end

  logic [DATA_WIDTH-1:0] a_d [2];
  logic [DATA_WIDTH-1:0] b_d [2];
  logic                  a_v [2];
  logic                  b_v [2];

  // Data registers only load alongside a valid beat, so readdata holds between beats.
  always_ff @(posedge clk) begin : read_pipe
    if (!reset_n) begin
      for (int p = 0; p < 2; p++) begin
        a_d[p] <= '0;
        a_v[p] <= 1'b0;
        b_d[p] <= '0;
        b_v[p] <= 1'b0;
      end
    end else if (en) begin
      for (int p = 0; p < 2; p++) begin
        a_v[p] <= rd[p];
        if (rd[p]) a_d[p] <= mem[addr[p]];
        b_v[p] <= a_v[p];
        if (a_v[p]) b_d[p] <= a_d[p];
      end
    end
  end

  assign s1.readdata      = (READ_LATENCY == 2) ? b_d[0] : a_d[0];
  assign s1.readdatavalid = (READ_LATENCY == 2) ? b_v[0] : a_v[0];
  assign s2.readdata      = (READ_LATENCY == 2) ? b_d[1] : a_d[1];
  assign s2.readdatavalid = (READ_LATENCY == 2) ? b_v[1] : a_v[1];

  always_ff @(posedge clk) begin : collision_cnt
    if (!reset_n) begin
      collision_count <= 16'h0000;
    end else if (en && collide && (collision_count != 16'hFFFF)) begin
      collision_count <= collision_count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_nios2core_onchip_memory_dp.sv
// Scoreboard bench: dut_a runs with read latency 1, dut_b with latency 2; stimulus
// pushes expected beats (data + due cycle) and a negedge monitor pops and compares.
module tb_nios2core_onchip_memory_dp;

  localparam int DW = 32;
  localparam int AW = 12;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n;
  logic clken;
  logic reset_req;
  logic [15:0] coll_a;
  logic [15:0] coll_b;

  always #5 clk = ~clk;

  nios2core_onchip_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa1 ();
  nios2core_onchip_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa2 ();
  nios2core_onchip_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb1 ();
  nios2core_onchip_memory_dp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb2 ();

  nios2core_onchip_memory_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
    .s1(ifa1), .s2(ifa2), .collision_count(coll_a)
  );

  nios2core_onchip_memory_dp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
    .s1(ifb1), .s2(ifb2), .collision_count(coll_b)
  );

  // Port index: 0 = A.s1, 1 = A.s2, 2 = B.s1, 3 = B.s2
  logic          cs_v [4];
  logic          rd_v [4];
  logic          wr_v [4];
  logic [AW-1:0] ad_v [4];
  logic [3:0]    be_v [4];
  logic [DW-1:0] wd_v [4];
  logic          rv   [4];
  logic [DW-1:0] rdd  [4];

  assign ifa1.chipselect = cs_v[0]; assign ifa1.read = rd_v[0]; assign ifa1.write = wr_v[0];
  assign ifa1.address = ad_v[0]; assign ifa1.byteenable = be_v[0]; assign ifa1.writedata = wd_v[0];
  assign ifa2.chipselect = cs_v[1]; assign ifa2.read = rd_v[1]; assign ifa2.write = wr_v[1];
  assign ifa2.address = ad_v[1]; assign ifa2.byteenable = be_v[1]; assign ifa2.writedata = wd_v[1];
  assign ifb1.chipselect = cs_v[2]; assign ifb1.read = rd_v[2]; assign ifb1.write = wr_v[2];
  assign ifb1.address = ad_v[2]; assign ifb1.byteenable = be_v[2]; assign ifb1.writedata = wd_v[2];
  assign ifb2.chipselect = cs_v[3]; assign ifb2.read = rd_v[3]; assign ifb2.write = wr_v[3];
  assign ifb2.address = ad_v[3]; assign ifb2.byteenable = be_v[3]; assign ifb2.writedata = wd_v[3];

  assign rv[0] = ifa1.readdatavalid; assign rdd[0] = ifa1.readdata;
  assign rv[1] = ifa2.readdatavalid; assign rdd[1] = ifa2.readdata;
  assign rv[2] = ifb1.readdatavalid; assign rdd[2] = ifb1.readdata;
  assign rv[3] = ifb2.readdatavalid; assign rdd[3] = ifb2.readdata;

  beat_t         exp_q [4][$];
  logic [DW-1:0] last  [4];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic          en_last = 1'b0;

  always @(posedge clk) begin
    cyc++;
    en_last = clken & ~reset_req;
  end

  task automatic mon(input int p);
    beat_t b;
    if (!reset_n) begin
      last[p] = '0;
      return;
    end
    while (exp_q[p].size() != 0 && exp_q[p][0].due < cyc) begin
      b = exp_q[p].pop_front();
      checks++; errors++;
      $display("FAIL missed_beat port %0d exp %h due %0d now %0d", p, b.data, b.due, cyc);
    end
    if (rv[p] && en_last) begin
      checks++;
      if (exp_q[p].size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid port %0d data %h cycle %0d", p, rdd[p], cyc);
      end else begin
        b = exp_q[p].pop_front();
        if (rdd[p] !== b.data || cyc != b.due) begin
          errors++;
          $display("FAIL beat port %0d data %h exp %h cycle %0d due %0d", p, rdd[p], b.data, cyc, b.due);
        end
        last[p] = b.data;
      end
    end else begin
      checks++;
      if (rdd[p] !== last[p]) begin
        errors++;
        $display("FAIL hold port %0d data %h exp %h cycle %0d", p, rdd[p], last[p], cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) mon(p);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int i);
    cs_v[i] = 1'b0; rd_v[i] = 1'b0; wr_v[i] = 1'b0;
    ad_v[i] = '0;   be_v[i] = '0;   wd_v[i] = '0;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) idle(i);
  endtask

  task automatic cmd(input int i, input logic cs, input logic r, input logic w,
                     input logic [AW-1:0] a, input logic [3:0] be, input logic [DW-1:0] d);
    cs_v[i] = cs; rd_v[i] = r; wr_v[i] = w; ad_v[i] = a; be_v[i] = be; wd_v[i] = d;
  endtask

  task automatic wr(input int i, input logic [AW-1:0] a, input logic [3:0] be, input logic [DW-1:0] d);
    cmd(i, 1'b1, 1'b0, 1'b1, a, be, d);
  endtask

  // due = accept edge + latency - 1 + frozen edges; accept edge is cyc+1.
  task automatic rd(input int i, input logic [AW-1:0] a, input logic [DW-1:0] exp, input int extra);
    beat_t b;
    cmd(i, 1'b1, 1'b1, 1'b0, a, 4'h0, '0);
    b.data = exp;
    b.due  = cyc + ((i < 2) ? 1 : 2) + extra;
    exp_q[i].push_back(b);
  endtask

  initial begin
    reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
    idle_all();
    repeat (3) step();
    reset_n = 1'b1;
    step();
    chk("reset_coll_a", {16'h0, coll_a}, 32'h0);
    chk("reset_coll_b", {16'h0, coll_b}, 32'h0);
    chk("reset_valid", {28'h0, rv[0], rv[1], rv[2], rv[3]}, 32'h0);

    // Write then cross-port read next cycle
    wr(0, 12'h005, 4'hF, 32'hDEADBEEF); step(); idle(0);
    rd(1, 12'h005, 32'hDEADBEEF, 0);    step(); idle(1);
    step();

    // Cross-port read during write returns old data, then new data
    wr(0, 12'h005, 4'hF, 32'h12345678); rd(1, 12'h005, 32'hDEADBEEF, 0); step(); idle(0);
    rd(1, 12'h005, 32'h12345678, 0);    step(); idle(1);

    // Read+write together is a write with no returned data
    cmd(0, 1'b1, 1'b1, 1'b1, 12'h020, 4'hF, 32'hCAFEF00D); step();
    rd(0, 12'h020, 32'hCAFEF00D, 0); step(); idle(0);

    // Byte enables at the top address
    wr(0, 12'hFFF, 4'hF, 32'h11223344);     step();
    wr(0, 12'hFFF, 4'b0101, 32'hAABBCCDD);  step();
    rd(0, 12'hFFF, 32'h11BB33DD, 0);        step(); idle(0);

    // Same-address collisions
    wr(0, 12'h010, 4'b0001, 32'h000000AA); wr(1, 12'h010, 4'b0011, 32'h0000BB00); step();
    idle_all();
    chk("coll_overlap", {16'h0, coll_a}, 32'h1);
    rd(0, 12'h010, 32'h0000BBAA, 0); step(); idle(0);
    wr(0, 12'h010, 4'b0001, 32'h000000CC); wr(1, 12'h010, 4'b0010, 32'h0000DD00); step();
    idle_all();
    chk("coll_disjoint", {16'h0, coll_a}, 32'h1);
    wr(0, 12'h011, 4'hF, 32'h01010101); wr(1, 12'h012, 4'hF, 32'h02020202); step();
    idle_all();
    chk("coll_diff_addr", {16'h0, coll_a}, 32'h1);
    cmd(0, 1'b0, 1'b0, 1'b1, 12'h010, 4'hF, 32'hFFFFFFFF); step();
    rd(0, 12'h010, 32'h0000DDCC, 0); step(); idle(0);

    // Back-to-back reads on both ports
    rd(0, 12'h005, 32'h12345678, 0); rd(1, 12'hFFF, 32'h11BB33DD, 0); step();
    rd(0, 12'h011, 32'h01010101, 0); rd(1, 12'h012, 32'h02020202, 0); step();
    idle_all(); step();

    // reset_req blocks writes and counter updates
    wr(0, 12'h030, 4'hF, 32'h00000055); step();
    reset_req = 1'b1;
    wr(0, 12'h030, 4'hF, 32'h00000066); wr(1, 12'h030, 4'hF, 32'h00000077); step();
    reset_req = 1'b0; idle_all();
    chk("coll_reset_req", {16'h0, coll_a}, 32'h1);
    rd(0, 12'h030, 32'h00000055, 0); step(); idle(0); step();

    // Latency 2 with a two-cycle clken freeze mid-stream
    wr(2, 12'h000, 4'hF, 32'h000000A0); step();
    wr(2, 12'h001, 4'hF, 32'h000000A1); step();
    wr(2, 12'h002, 4'hF, 32'h000000A2); step();
    rd(2, 12'h000, 32'h000000A0, 0); step();
    rd(2, 12'h001, 32'h000000A1, 2); step();
    idle(2); clken = 1'b0; step(); step();
    clken = 1'b1;
    rd(2, 12'h002, 32'h000000A2, 0); step(); idle(2);
    rd(3, 12'h001, 32'h000000A1, 0); step(); idle(3);
    repeat (3) step();

    // Reset while a latency-2 read is in flight
    wr(2, 12'h100, 4'hF, 32'h0BADF00D); wr(3, 12'h101, 4'hF, 32'h0000000F); step();
    wr(2, 12'h101, 4'hF, 32'h000000F0); wr(3, 12'h101, 4'hF, 32'h00000F00); step();
    idle_all();
    chk("coll_b_before_reset", {16'h0, coll_b}, 32'h1);
    cmd(2, 1'b1, 1'b1, 1'b0, 12'h100, 4'h0, '0); step();
    idle_all(); reset_n = 1'b0; clken = 1'b0; step(); step();
    reset_n = 1'b1; step();
    chk("coll_a_after_reset", {16'h0, coll_a}, 32'h0);
    chk("coll_b_after_reset", {16'h0, coll_b}, 32'h0);
    clken = 1'b1; step();
    rd(2, 12'h100, 32'h0BADF00D, 0); rd(0, 12'hFFF, 32'h11BB33DD, 0); step();
    rd(3, 12'h101, 32'h000000F0, 0); idle(0); idle(2); step();
    idle_all();
    repeat (5) step();

    for (int p = 0; p < 4; p++) chk("queue_empty", exp_q[p].size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
